uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one `uart` transmitter between N byte-stream requesters. Arbitration is round-robin, with an optional packet lock that holds the grant until the requester's `last` byte has been sent. The block drives the uart's `tx_data`/`tx_rdy` and sequences each byte on the uart's `tx_complete`. A watchdog releases a stuck grant.

## Interface
Parameters:
- `N`, 4: number of requesters, 2..8.
- `TIMEOUT_CYC`, 24'd2_000_000: cycles allowed for one byte (WAIT) or for a locked owner's next byte (HOLD).

Ports:
- `clk`  in  1  system clock; only clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `req_valid`  in  N  requester i has a byte.
- `req_data`  in  N*8  byte of requester i, at bits [8i+7:8i].
- `req_last`  in  N  byte is last of packet; ends the lock.
- `req_ready`  out  N  one-hot. Byte is accepted in the cycle where `req_valid[i] & req_ready[i]`.
- `uart_tx_data`  out  8  to uart `tx_data`; registered, stable from acceptance until `uart_tx_complete`.
- `uart_tx_rdy`  out  1  to uart `tx_rdy`; one-cycle start pulse.
- `uart_tx_complete`  in  1  from uart; one-cycle pulse when the stop bits are done.
- `grant`  out  N  one-hot current owner; 0 when idle.
- `busy`  out  1  state != IDLE.
- `timeout_err`  out  1  one-cycle pulse when the watchdog fires.

## Operation
- States:
  - IDLE: no owner.
  - START: pulse `uart_tx_rdy`.
  - WAIT: frame in flight.
  - HOLD: locked owner, awaiting its next byte.
- Round-robin pointer `ptr` (0..N-1). Search starts at `ptr` and wraps. After each grant is released, `ptr` = owner+1 mod N.
- IDLE:
  - Pick the winner combinationally among `req_valid`.
  - Assert `req_ready[w]`, load `uart_tx_data`, set `grant`, set `lock` = !`req_last[w]`.
  - Go to START.
- START: `uart_tx_rdy`=1 for exactly one cycle; go to WAIT. Watchdog cleared.
- WAIT, on `uart_tx_complete`:
  - If `lock`, go to HOLD.
  - Otherwise release the grant, advance `ptr`, go to IDLE.
- HOLD:
  - Only the owner is eligible; `req_ready` is combinational, for the owner only.
  - On owner valid: accept the byte, update `lock`, go to START.
  - Other requesters stay blocked.
- Watchdog: counter runs in WAIT and HOLD and is cleared on entry to either state. When it reaches `TIMEOUT_CYC`-1:
  - pulse `timeout_err`;
  - clear `lock`, release the grant, advance `ptr`;
  - go to IDLE.
- Simultaneous `uart_tx_complete` and watchdog expiry in WAIT: complete wins, no error.
- `uart_tx_complete` outside WAIT: ignored.
- Counter width is 24 bits and saturates; it never wraps.

## Timing
- Reset values:
  - all outputs 0 (`uart_tx_data`=8'h00, `grant`=0, `req_ready`=0, `busy`=0, `timeout_err`=0);
  - state IDLE, `ptr`=0, `lock`=0, counter 0.
- Accept in cycle t (IDLE or HOLD) gives `uart_tx_rdy` high in cycle t+1.
- `uart_tx_complete` in cycle k:
  - next acceptance is possible in k+1;
  - next `uart_tx_rdy` is no earlier than k+2.
- Throughput: one byte per uart frame plus 2 cycles.
- `req_ready` is never asserted in START or WAIT.
- `req_ready[i]` for i ≠ owner is never asserted in HOLD.
- Reset mid-frame clears everything immediately and asynchronously. The uart shares `rst`, so no partial frame survives.

## Structure
- Package `uart_pkg`: state enum `arb_state_t` (IDLE, START, WAIT, HOLD) and the timeout counter width constant `ARB_TO_W`=24.
- Sub-module `rr_arbiter`: combinational N-way round-robin pick.
  - Inputs: `req` [N], `ptr`.
  - Outputs: `gnt` one-hot, `any`.
- The FSM, data register and watchdog live in the top.

## Test plan
- Single byte: req0 sends 8'hA5 with last=1, uart model completes after 100 cycles.
  - Required: `req_ready[0]` at t, `uart_tx_rdy` at t+1, `uart_tx_data`=8'hA5 through completion, back to IDLE, `ptr`=1.
- Round-robin: all 4 requesters valid continuously with last=1.
  - Required: grant order 0,1,2,3,0, `ptr` wrapping 3→0.
- Packet lock: req1 sends 3 bytes, last on the 3rd, while req2 is valid throughout.
  - Required: all 3 bytes of req1 go before any byte of req2; req2 is granted right after.
- HOLD timeout: req3 sends a byte with last=0, then drops valid; `TIMEOUT_CYC`=50.
  - Required: `timeout_err` pulses 50 cycles after entering HOLD; grant is released; req0 is then served.
- WAIT timeout with collision: the uart never completes.
  - Required: `timeout_err` fires after 50 cycles.
  - Rerun with `uart_tx_complete` on the expiry cycle: no `timeout_err`.
- Reset mid-frame: assert `rst` during WAIT.
  - Required: all outputs go to 0 without waiting for a clock; after release the first grant goes to req0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the uart transmit arbiter: FSM state encoding and watchdog width.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } arb_state_t;

  localparam int unsigned ARB_TO_W = 24;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          any
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && req[PW'((32'(ptr) + k) % N)]) begin
        gnt[PW'((32'(ptr) + k) % N)] = 1'b1;
        found                        = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart transmitter between N byte-stream requesters with round-robin
// arbitration, optional packet lock and a watchdog that frees a stuck grant.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned         N           = 4,
  parameter logic [ARB_TO_W-1:0] TIMEOUT_CYC = 24'd2_000_000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [N*8-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic [7:0]     uart_tx_data,
  output logic           uart_tx_rdy,
  input  logic           uart_tx_complete,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic           timeout_err
);

  localparam int unsigned         PW       = $clog2(N);
  localparam logic [ARB_TO_W-1:0] WD_LAST  = TIMEOUT_CYC - ARB_TO_W'(1);
  localparam logic [PW-1:0]       PTR_LAST = PW'(N - 1);

  arb_state_t          state;
  logic [PW-1:0]       ptr;
  logic [PW-1:0]       owner;
  logic                lock;
  logic [ARB_TO_W-1:0] wd;

  logic [N-1:0]        rr_gnt;
  logic                rr_any;
  logic [7:0]          sel_data;
  logic                sel_last;
  logic [PW-1:0]       sel_idx;
  logic                accept;
  logic [PW-1:0]       ptr_adv;
  logic [ARB_TO_W-1:0] wd_inc;
  logic                wd_expired;

  rr_arbiter #(
    .N  (N),
    .PW (PW)
  ) u_rr (
    .req (req_valid),
    .ptr (ptr),
    .gnt (rr_gnt),
    .any (rr_any)
  );

  // Ready is combinational so a byte can be taken in the same cycle it is offered;
  // held low during reset so every output reads zero.
  always_comb begin
    req_ready = '0;
    if (!rst) begin
      if (state == IDLE && rr_any) begin
        req_ready = rr_gnt;
      end else if (state == HOLD) begin
        req_ready = grant & req_valid;
      end
    end
  end

  // Mux the accepted requester's byte, last flag and index.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    sel_idx  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        sel_data = req_data[8*i +: 8];
        sel_last = req_last[i];
        sel_idx  = PW'(i);
      end
    end
  end

  assign accept     = |req_ready;
  assign ptr_adv    = (owner == PTR_LAST) ? '0 : owner + PW'(1);
  assign wd_inc     = (wd == '1) ? wd : wd + ARB_TO_W'(1);
  assign wd_expired = (wd == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      owner        <= '0;
      lock         <= 1'b0;
      wd           <= '0;
      uart_tx_data <= '0;
      uart_tx_rdy  <= 1'b0;
      grant        <= '0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      uart_tx_rdy <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            uart_tx_data <= sel_data;
            grant        <= req_ready;
            owner        <= sel_idx;
            lock         <= !sel_last;
            uart_tx_rdy  <= 1'b1;
            busy         <= 1'b1;
            state        <= START;
          end
        end
        START: begin
          wd    <= '0;
          state <= WAIT;
        end
        // A completion on the expiry cycle still counts as a good frame.
        WAIT: begin
          if (uart_tx_complete) begin
            wd <= '0;
            if (lock) begin
              state <= HOLD;
            end else begin
              grant <= '0;
              busy  <= 1'b0;
              ptr   <= ptr_adv;
              state <= IDLE;
            end
          end else if (wd_expired) begin
            timeout_err <= 1'b1;
            lock        <= 1'b0;
            grant       <= '0;
            busy        <= 1'b0;
            ptr         <= ptr_adv;
            state       <= IDLE;
          end else begin
            wd <= wd_inc;
          end
        end
        // The owner's byte arriving on the expiry cycle is still taken.
        HOLD: begin
          if (accept) begin
            uart_tx_data <= sel_data;
            lock         <= !sel_last;
            uart_tx_rdy  <= 1'b1;
            state        <= START;
          end else if (wd_expired) begin
            timeout_err <= 1'b1;
            lock        <= 1'b0;
            grant       <= '0;
            busy        <= 1'b0;
            ptr         <= ptr_adv;
            state       <= IDLE;
          end else begin
            wd <= wd_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model built on grant deadlines.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 50;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     uart_tx_data;
  logic           uart_tx_rdy;
  logic           uart_tx_complete;
  logic [N-1:0]   grant;
  logic           busy;
  logic           timeout_err;

  uart_tx_arbiter #(
    .N           (N),
    .TIMEOUT_CYC (24'(TO))
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_last         (req_last),
    .req_ready        (req_ready),
    .uart_tx_data     (uart_tx_data),
    .uart_tx_rdy      (uart_tx_rdy),
    .uart_tx_complete (uart_tx_complete),
    .grant            (grant),
    .busy             (busy),
    .timeout_err      (timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  // Requester byte queues, entries are {last, data}.
  logic [8:0] q [N][$];
  int         hold_off [N];
  int         n_push = 0;
  int         n_pop  = 0;
  int         n_to   = 0;
  bit         gen_en = 1'b0;
  bit         spur_en = 1'b0;

  // Reference model state: owner (-1 = none), rotation pointer, lock, deadlines.
  int         m_owner, m_ptr, m_acc, m_deadline;
  bit         m_lock, m_hold;
  logic [7:0] m_data;

  // Uart responder: 0 random, 1 fixed delay, 2 never completes, 3 completes on expiry.
  int u_mode  = 1;
  int u_fixed = 5;
  int u_comp  = -1;
  bit u_busy  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic void model_release();
    m_ptr   = (m_owner + 1) % N;
    m_owner = -1;
    m_lock  = 1'b0;
    m_hold  = 1'b0;
  endfunction

  function automatic void model_reset();
    m_owner    = -1;
    m_ptr      = 0;
    m_lock     = 1'b0;
    m_hold     = 1'b0;
    m_acc      = cyc - 10;
    m_deadline = -1;
    m_data     = 8'h00;
    u_busy     = 1'b0;
    u_comp     = -1;
  endfunction

  task automatic push_pkt(input int r, input int len, input logic [7:0] b);
    for (int k = 0; k < len; k++) begin
      q[r].push_back({(k == len - 1) ? 1'b1 : 1'b0, 8'(b + k)});
      n_push++;
    end
  endtask

  function automatic bit traffic_left();
    for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1'b1;
    return m_owner >= 0;
  endfunction

  // One clock: drive inputs at the falling edge, sample 1ns later, check, update.
  task automatic step();
    int         w;
    bit         exp_to, frame;
    logic [N-1:0] exp_ready;
    logic [8:0] ent;
    @(negedge clk);
    cyc++;
    if (gen_en) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 39) == 0 && q[i].size() < 4)
          push_pkt(i, $urandom_range(1, 3), 8'($urandom));
    end
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (q[i].size() > 0) && (cyc >= hold_off[i]);
      if (q[i].size() > 0) begin
        ent               = q[i][0];
        req_last[i]       = ent[8];
        req_data[8*i +: 8] = ent[7:0];
      end else begin
        req_last[i]       = 1'($urandom);
        req_data[8*i +: 8] = 8'($urandom);
      end
    end
    uart_tx_complete = (cyc == u_comp) || (spur_en && !u_busy && $urandom_range(0, 29) == 0);
    #1;

    exp_to = 1'b0;
    if (m_owner >= 0 && cyc == m_deadline) begin
      exp_to = 1'b1;
      model_release();
    end
    w = -1;
    if (m_owner < 0) w = rr_pick(req_valid, m_ptr);
    else if (m_hold && req_valid[m_owner]) w = m_owner;
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;

    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("tx_rdy", 32'(uart_tx_rdy), 32'(cyc == m_acc + 1));
    chk("timeout_err", 32'(timeout_err), 32'(exp_to));
    chk("grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    if (m_owner >= 0) chk("tx_data", 32'(uart_tx_data), 32'(m_data));

    frame = (m_owner >= 0) && !m_hold && (cyc >= m_acc + 2);
    if (uart_tx_complete && frame) begin
      if (m_lock) begin
        m_hold     = 1'b1;
        m_deadline = cyc + TO + 1;
      end else begin
        model_release();
      end
    end
    if (w >= 0) begin
      m_owner    = w;
      m_lock     = !req_last[w];
      m_hold     = 1'b0;
      m_acc      = cyc;
      m_deadline = cyc + TO + 2;
      m_data     = req_data[8*w +: 8];
    end

    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i] && q[i].size() > 0) begin
        ent = q[i].pop_front();
        n_pop++;
        if (gen_en && !ent[8]) begin
          case ($urandom_range(0, 7))
            0:       hold_off[i] = cyc + 80;
            1, 2:    hold_off[i] = cyc + $urandom_range(1, 10);
            default: ;
          endcase
        end
      end
    end
    if (timeout_err) n_to++;
    if (uart_tx_complete && cyc == u_comp) begin
      u_busy = 1'b0;
      u_comp = -1;
    end
    if (timeout_err) begin
      u_busy = 1'b0;
      u_comp = -1;
    end
    if (uart_tx_rdy) begin
      u_busy = 1'b1;
      case (u_mode)
        1:       u_comp = cyc + u_fixed;
        2:       u_comp = -1;
        3:       u_comp = cyc + TO;
        default: begin
          case ($urandom_range(0, 19))
            0:       u_comp = -1;
            1:       u_comp = cyc + TO;
            default: u_comp = cyc + $urandom_range(1, 30);
          endcase
        end
      endcase
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (traffic_left() && k < 3000) begin
      step();
      k++;
    end
    chk(tag, 32'(k < 3000), 32'd1);
  endtask

  initial begin
    #600_000;
    $display("FAIL global_timeout @cyc %0d: got running, expected finished", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int k;
    int to_before;
    rst              = 1'b1;
    req_valid        = '1;
    req_data         = '0;
    req_last         = '1;
    uart_tx_complete = 1'b0;
    for (int i = 0; i < N; i++) hold_off[i] = 0;
    model_reset();
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_data", 32'(uart_tx_data), 32'd0);
    chk("rst_tx_rdy", 32'(uart_tx_rdy), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    // Single byte from requester 0.
    u_mode  = 1;
    u_fixed = 40;
    push_pkt(0, 1, 8'hA5);
    run(60);

    // All requesters with single-byte packets, requester 0 twice.
    u_fixed = 5;
    for (int i = 0; i < N; i++) push_pkt(i, 1, 8'(8'h10 * i + 1));
    push_pkt(0, 1, 8'hE0);
    drain("drain_rr");

    // Locked three-byte packet against a competing requester.
    push_pkt(1, 3, 8'h30);
    push_pkt(2, 1, 8'h40);
    drain("drain_lock");

    // Locked owner disappears: watchdog in HOLD, then requester 0 is served.
    to_before = n_to;
    q[3].push_back({1'b0, 8'h33});
    n_push++;
    run(80);
    chk("hold_timeout_seen", 32'(n_to - to_before), 32'd1);
    push_pkt(0, 1, 8'h44);
    drain("drain_hold_to");

    // Uart never completes, then completes exactly on the expiry cycle.
    to_before = n_to;
    u_mode = 2;
    push_pkt(2, 1, 8'h55);
    run(70);
    chk("wait_timeout_seen", 32'(n_to - to_before), 32'd1);
    to_before = n_to;
    u_mode = 3;
    push_pkt(2, 1, 8'h66);
    run(70);
    chk("collide_no_timeout", 32'(n_to - to_before), 32'd0);

    // Random traffic, stalls, hangs and spurious completions.
    u_mode  = 0;
    gen_en  = 1'b1;
    spur_en = 1'b1;
    run(4000);
    gen_en  = 1'b0;
    spur_en = 1'b0;
    drain("drain_random");

    // Reset in the middle of a frame.
    u_mode  = 1;
    u_fixed = 200;
    push_pkt(1, 1, 8'h77);
    k = 0;
    while (!(m_owner >= 0 && cyc >= m_acc + 4) && k < 100) begin
      step();
      k++;
    end
    chk("reach_wait", 32'(k < 100), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_tx_data", 32'(uart_tx_data), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    uart_tx_complete = 1'b0;
    model_reset();
    u_fixed = 5;
    for (int i = N - 1; i >= 0; i--) push_pkt(i, 1, 8'(8'hC0 + i));
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    drain("drain_after_rst");

    chk("byte_count", 32'(n_pop), 32'(n_push));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
